task8_cpu_ocimem_sequencer: RTL and testbench
=============================================

TASK8_CPU_OCIMEM_SEQUENCER -- requirements
Module: task8_cpu_ocimem_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 255; the maximum number of cycles mem_wait may stall one access (range 1..255).
REQ-002 clk  in  1  system clock; all state on its rising edge.
REQ-003 reset_n  in  1  reset, asynchronous and active-low.
REQ-004 jdo  in  38  JTAG debug data word, sampled only in a command cycle.
REQ-005 take_action_ocimem_a  in  1  one-cycle pulse: load address jdo[25:18]; read there if jdo[35]=1.
REQ-006 take_action_ocimem_b  in  1  one-cycle pulse: write jdo[34:3] at the current address.
REQ-007 take_no_action_ocimem_a  in  1  one-cycle pulse: read at the current address.
REQ-008 mem_addr  out  8  debug RAM address (the current address register).
REQ-009 mem_wdata  out  32  write data, held for the whole write.
REQ-010 mem_rd / mem_wr  out  1 each  access strobes; never both high.
REQ-011 mem_wait  in  1  RAM stall; a strobe completes in the first cycle with mem_wait=0.
REQ-012 mem_rdata  in  32  read data, valid in the cycle after read completion.
REQ-013 MonDReg  out  32  last read data.
REQ-014 monitor_ready  out  1  last command finished.
REQ-015 monitor_error  out  1  sticky error flag.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states are IDLE, WR, RD and RD_CAP; commands are accepted only in IDLE.
REQ-018 Priority when pulses coincide in IDLE: ocimem_a, then ocimem_b, then no_action_a; each lower pulse is dropped and sets monitor_error.
REQ-019 Any command pulse arriving while busy=1 is dropped, sets monitor_error, and does not alter the operation in progress.
REQ-020 ocimem_a accepted: mem_addr<=jdo[25:18]; monitor_error<=0; if jdo[35]=1 go to RD, else stay IDLE with monitor_ready=1 next cycle.
REQ-021 ocimem_b accepted: mem_wdata<=jdo[34:3]; monitor_ready<=0; go to WR.
REQ-022 no_action_a accepted: monitor_ready<=0; go to RD.
REQ-023 WR: mem_wr=1 until mem_wait=0; then IDLE, mem_addr<=mem_addr+1, monitor_ready<=1.
REQ-024 RD: mem_rd=1 until mem_wait=0; then go to RD_CAP.
REQ-025 RD_CAP: MonDReg<=mem_rdata, mem_addr<=mem_addr+1, monitor_ready<=1; go to IDLE.
REQ-026 Latency with no stall:
- Write pulse in cycle N: mem_wr high in N+1; monitor_ready high in N+2.
- Read pulse in N: mem_rd high in N+1; MonDReg and monitor_ready valid in N+3.
REQ-027 The address increment is modulo 256 (0xFF -> 0x00); a read-with-load at 0xFF leaves mem_addr=0x00.
REQ-028 An 8-bit stall counter clears on entry to WR or RD and increments every cycle with mem_wait=1.
REQ-029 Timeout: when the counter reaches TIMEOUT with mem_wait still 1:
- drop the strobe and go to IDLE;
- monitor_error<=1 and monitor_ready<=1;
- mem_addr and MonDReg unchanged.
REQ-030 monitor_error is cleared only by an accepted ocimem_a or by reset.

Reset
REQ-031 With reset_n=0: state=IDLE, mem_addr=0, mem_wdata=0, MonDReg=0, counter=0, mem_rd=mem_wr=0, monitor_ready=1, monitor_error=0, busy=0.
REQ-032 Deasserting reset_n mid-access abandons the access; no strobe is asserted in the first cycle after release.

Verification
REQ-033 ocimem_a with jdo[25:18]=0x10, jdo[35]=0 -> next cycle mem_addr=0x10, monitor_ready=1, no strobe.
REQ-034 ocimem_b with jdo[34:3]=0xDEADBEEF, mem_wait=0 -> mem_wr=1 for one cycle at addr 0x10; two cycles after the pulse monitor_ready=1 and mem_addr=0x11.
REQ-035 no_action_a at 0xFF, mem_wait high 3 cycles, mem_rdata=0x12345678 -> mem_rd high 4 cycles, MonDReg=0x12345678, mem_addr=0x00.
REQ-036 ocimem_b and no_action_a in the same cycle -> only the write executes; monitor_error=1 until the next ocimem_a.
REQ-037 mem_wait held high with TIMEOUT=4 -> strobe drops after the 4th stall cycle; monitor_error=1, mem_addr unchanged, FSM in IDLE.
REQ-038 reset_n pulsed low during RD -> all outputs at REQ-031 values immediately; no strobe after release.

Source files
------------

// File: rtl/task8_cpu_ocimem_sequencer_if.sv
// Bundles the JTAG command pulses, debug-RAM port and monitor status of the OCI memory sequencer.
// The slave modport is the sequencer's view; the master modport is the debugger/RAM side.
interface task8_cpu_ocimem_sequencer_if;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_wait;
    logic [31:0] mem_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        busy;

    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        output mem_wait, mem_rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, MonDReg, monitor_ready, monitor_error, busy
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        input  mem_wait, mem_rdata,
        output mem_addr, mem_wdata, mem_rd, mem_wr, MonDReg, monitor_ready, monitor_error, busy
    );
endinterface

// File: rtl/task8_cpu_ocimem_sequencer.sv
// Sequences JTAG-issued debug RAM reads/writes with wait-state handling, a stall timeout
// and a sticky error flag for dropped or timed-out commands.
module task8_cpu_ocimem_sequencer #(
    parameter int TIMEOUT = 255
) (
    input logic                          clk,
    input logic                          reset_n,
    task8_cpu_ocimem_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WR, RD, RD_CAP} state_t;

    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  addr_q, addr_next;
    logic [31:0] wdata_q, wdata_next;
    logic [31:0] mon_q, mon_next;
    logic        ready_q, ready_next;
    logic        error_q, error_next;
    logic [7:0]  stall_q, stall_next;
    logic        any_cmd;
    logic        unused_jdo;

    assign unused_jdo = ^{bus.jdo[37:36], bus.jdo[2:0]};
    assign any_cmd    = bus.take_action_ocimem_a | bus.take_action_ocimem_b |
                        bus.take_no_action_ocimem_a;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mon_q   <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            stall_q <= '0;
        end else begin
            state   <= state_next;
            addr_q  <= addr_next;
            wdata_q <= wdata_next;
            mon_q   <= mon_next;
            ready_q <= ready_next;
            error_q <= error_next;
            stall_q <= stall_next;
        end
    end

    // In IDLE the highest-priority pulse wins and any coincident lower pulse flags an error,
    // even when that winner is the error-clearing ocimem_a.
    always_comb begin
        state_next = state;
        addr_next  = addr_q;
        wdata_next = wdata_q;
        mon_next   = mon_q;
        ready_next = ready_q;
        error_next = error_q;
        stall_next = stall_q;
        case (state)
            IDLE: begin
                if (bus.take_action_ocimem_a) begin
                    addr_next  = bus.jdo[25:18];
                    error_next = bus.take_action_ocimem_b | bus.take_no_action_ocimem_a;
                    if (bus.jdo[35]) begin
                        state_next = RD;
                        ready_next = 1'b0;
                        stall_next = '0;
                    end else begin
                        ready_next = 1'b1;
                    end
                end else if (bus.take_action_ocimem_b) begin
                    wdata_next = bus.jdo[34:3];
                    ready_next = 1'b0;
                    stall_next = '0;
                    state_next = WR;
                    if (bus.take_no_action_ocimem_a) begin
                        error_next = 1'b1;
                    end
                end else if (bus.take_no_action_ocimem_a) begin
                    ready_next = 1'b0;
                    stall_next = '0;
                    state_next = RD;
                end
            end
            WR, RD: begin
                if (any_cmd) begin
                    error_next = 1'b1;
                end
                if (!bus.mem_wait) begin
                    if (state == WR) begin
                        state_next = IDLE;
                        addr_next  = addr_q + 8'd1;
                        ready_next = 1'b1;
                    end else begin
                        state_next = RD_CAP;
                    end
                end else begin
                    stall_next = stall_q + 8'd1;
                    // The TIMEOUT-th consecutive stall cycle abandons the access untouched.
                    if (stall_q == STALL_LIMIT) begin
                        state_next = IDLE;
                        error_next = 1'b1;
                        ready_next = 1'b1;
                    end
                end
            end
            RD_CAP: begin
                if (any_cmd) begin
                    error_next = 1'b1;
                end
                mon_next   = bus.mem_rdata;
                addr_next  = addr_q + 8'd1;
                ready_next = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wr        = (state == WR);
    assign bus.mem_rd        = (state == RD);
    assign bus.MonDReg       = mon_q;
    assign bus.monitor_ready = ready_q;
    assign bus.monitor_error = error_q;
    assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_task8_cpu_ocimem_sequencer.sv
// Randomized and directed bench for the OCI memory sequencer against a transaction-level model.
module tb_task8_cpu_ocimem_sequencer;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    task8_cpu_ocimem_sequencer_if bus();

    task8_cpu_ocimem_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level expectations
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_mon;
    logic        m_ready, m_err;
    int          exp_strobes, exp_busy, exp_kind;

    // Observations of the last command
    int          obs_strobes, obs_busy;
    bit          obs_first, obs_overlap, obs_hang, obs_wr, obs_rd, obs_ready_bad;
    logic [7:0]  obs_first_addr;

    task automatic model_reset();
        m_addr = '0; m_wdata = '0; m_mon = '0; m_ready = 1'b1; m_err = 1'b0;
    endtask

    // Drives one command, serves the RAM side with `stall` wait cycles and updates the model.
    task automatic do_cmd(input bit a, input bit b, input bit na, input logic [37:0] j,
                          input int stall, input logic [31:0] rdata, input bit inject);
        int kind;
        kind = 0;
        if (a) begin
            m_addr = j[25:18];
            m_err  = b | na;
            if (j[35]) kind = 2; else m_ready = 1'b1;
        end else if (b) begin
            m_wdata = j[34:3];
            kind = 1;
            if (na) m_err = 1'b1;
        end else if (na) begin
            kind = 2;
        end
        exp_kind = kind; exp_strobes = 0; exp_busy = 0;
        if (kind != 0) begin
            if (stall >= TIMEOUT) begin
                exp_strobes = TIMEOUT; exp_busy = TIMEOUT; m_err = 1'b1;
            end else begin
                exp_strobes = stall + 1;
                exp_busy    = stall + 1 + ((kind == 2) ? 1 : 0);
                m_addr      = m_addr + 8'd1;
                if (kind == 2) m_mon = rdata;
            end
            m_ready = 1'b1;
            if (inject) m_err = 1'b1;
        end

        bus.jdo = j;
        bus.take_action_ocimem_a = a;
        bus.take_action_ocimem_b = b;
        bus.take_no_action_ocimem_a = na;
        bus.mem_wait = 1'b0;
        bus.mem_rdata = ~rdata;
        @(posedge clk); #1;
        bus.take_action_ocimem_b = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.jdo = 38'({$urandom(), $urandom()});
        obs_strobes = 0; obs_busy = 0; obs_overlap = 0; obs_wr = 0; obs_rd = 0; obs_ready_bad = 0;
        obs_first = bus.mem_rd | bus.mem_wr;
        obs_first_addr = bus.mem_addr;
        obs_hang = 1;
        for (int c = 0; c < 40; c++) begin
            bus.take_action_ocimem_a = 1'b0;
            if (bus.mem_rd && bus.mem_wr) obs_overlap = 1;
            if (!bus.busy) begin
                obs_hang = 0;
                break;
            end
            obs_busy++;
            if (bus.monitor_ready) obs_ready_bad = 1;
            if (bus.mem_rd || bus.mem_wr) begin
                obs_strobes++;
                if (bus.mem_wr) obs_wr = 1;
                if (bus.mem_rd) obs_rd = 1;
                bus.mem_wait  = (obs_strobes <= stall);
                bus.mem_rdata = ~rdata;
            end else begin
                bus.mem_wait  = 1'b0;
                bus.mem_rdata = rdata;
            end
            if (inject && c == 0) bus.take_action_ocimem_a = 1'b1;
            @(posedge clk); #1;
        end
        bus.take_action_ocimem_a = 1'b0;
        bus.mem_wait = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.jdo = '0; bus.take_action_ocimem_a = 0; bus.take_action_ocimem_b = 0;
        bus.take_no_action_ocimem_a = 0; bus.mem_wait = 0; bus.mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.mem_rd, bus.mem_wr, bus.busy, bus.monitor_ready, bus.monitor_error} !== 5'b00010) begin
            bad++; $display("[TB] FAIL reset_flags: got %b want 00010",
                {bus.mem_rd, bus.mem_wr, bus.busy, bus.monitor_ready, bus.monitor_error});
        end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.MonDReg} !== 72'h0) begin
            bad++; $display("[TB] FAIL reset_regs: got %h %h %h want 0", bus.mem_addr, bus.mem_wdata, bus.MonDReg);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_addr();
        logic [37:0] j;
        j = '0; j[25:18] = 8'h10;
        do_cmd(1, 0, 0, j, 0, 32'h0, 0);
        total++;
        if (obs_strobes !== 0 || obs_busy !== 0 || obs_hang) begin
            bad++; $display("[TB] FAIL load_no_strobe: got strobes=%0d busy=%0d want 0 0", obs_strobes, obs_busy);
        end
        total++;
        if (bus.mem_addr !== 8'h10 || bus.monitor_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL load_addr: got addr=%h ready=%b want 10 1", bus.mem_addr, bus.monitor_ready);
        end
    endtask

    task automatic test_write();
        logic [37:0] j;
        j = '0; j[34:3] = 32'hDEADBEEF;
        do_cmd(0, 1, 0, j, 0, 32'h0, 0);
        total++;
        if (!obs_first || !obs_wr || obs_rd || obs_first_addr !== 8'h10 || obs_strobes !== 1) begin
            bad++; $display("[TB] FAIL write_strobe: got first=%b wr=%b rd=%b addr=%h n=%0d want 1 1 0 10 1",
                obs_first, obs_wr, obs_rd, obs_first_addr, obs_strobes);
        end
        total++;
        if (obs_busy !== 1 || bus.mem_addr !== 8'h11 || bus.monitor_ready !== 1'b1 || bus.mem_wdata !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL write_done: got busy=%0d addr=%h ready=%b wdata=%h want 1 11 1 deadbeef",
                obs_busy, bus.mem_addr, bus.monitor_ready, bus.mem_wdata);
        end
    endtask

    task automatic test_read_wrap();
        logic [37:0] j;
        j = '0; j[25:18] = 8'hFF;
        do_cmd(1, 0, 0, j, 0, 32'h0, 0);
        do_cmd(0, 0, 1, '0, 3, 32'h12345678, 0);
        total++;
        if (!obs_rd || obs_strobes !== 4 || obs_busy !== 5) begin
            bad++; $display("[TB] FAIL read_stall: got rd=%b n=%0d busy=%0d want 1 4 5", obs_rd, obs_strobes, obs_busy);
        end
        total++;
        if (bus.MonDReg !== 32'h12345678 || bus.mem_addr !== 8'h00) begin
            bad++; $display("[TB] FAIL read_wrap: got mon=%h addr=%h want 12345678 00", bus.MonDReg, bus.mem_addr);
        end
        j = '0; j[25:18] = 8'hFF; j[35] = 1'b1;
        do_cmd(1, 0, 0, j, 0, 32'hA5A5_0001, 0);
        total++;
        if (bus.mem_addr !== 8'h00 || bus.MonDReg !== 32'hA5A5_0001 || !obs_first) begin
            bad++; $display("[TB] FAIL load_read_wrap: got addr=%h mon=%h first=%b want 00 a5a50001 1",
                bus.mem_addr, bus.MonDReg, obs_first);
        end
    endtask

    task automatic test_priority();
        logic [37:0] j;
        j = '0; j[34:3] = 32'hCAFEF00D;
        do_cmd(0, 1, 1, j, 0, 32'h0, 0);
        total++;
        if (!obs_wr || obs_rd || bus.mem_wdata !== 32'hCAFEF00D || bus.monitor_error !== 1'b1) begin
            bad++; $display("[TB] FAIL prio_b_over_na: got wr=%b rd=%b wdata=%h err=%b want 1 0 cafef00d 1",
                obs_wr, obs_rd, bus.mem_wdata, bus.monitor_error);
        end
        do_cmd(0, 0, 1, '0, 1, 32'h0BAD_F00D, 0);
        total++;
        if (bus.monitor_error !== 1'b1) begin
            bad++; $display("[TB] FAIL err_sticky: got %b want 1", bus.monitor_error);
        end
        j = '0; j[25:18] = 8'h40;
        do_cmd(1, 0, 0, j, 0, 32'h0, 0);
        total++;
        if (bus.monitor_error !== 1'b0 || bus.mem_addr !== 8'h40) begin
            bad++; $display("[TB] FAIL err_clear: got err=%b addr=%h want 0 40", bus.monitor_error, bus.mem_addr);
        end
    endtask

    task automatic test_timeout();
        logic [37:0] j;
        j = '0; j[34:3] = 32'h1111_2222;
        do_cmd(0, 1, 0, j, 10, 32'h0, 0);
        total++;
        if (obs_strobes !== TIMEOUT || obs_busy !== TIMEOUT || obs_hang) begin
            bad++; $display("[TB] FAIL wr_timeout_len: got n=%0d busy=%0d want %0d", obs_strobes, obs_busy, TIMEOUT);
        end
        total++;
        if (bus.monitor_error !== 1'b1 || bus.mem_addr !== 8'h40 || bus.busy !== 1'b0 || bus.monitor_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL wr_timeout_state: got err=%b addr=%h busy=%b ready=%b want 1 40 0 1",
                bus.monitor_error, bus.mem_addr, bus.busy, bus.monitor_ready);
        end
        do_cmd(0, 0, 1, '0, 7, 32'h7777_7777, 0);
        total++;
        if (bus.MonDReg !== m_mon || bus.mem_addr !== 8'h40 || obs_strobes !== TIMEOUT) begin
            bad++; $display("[TB] FAIL rd_timeout: got mon=%h addr=%h n=%0d want %h 40 %0d",
                bus.MonDReg, bus.mem_addr, obs_strobes, m_mon, TIMEOUT);
        end
    endtask

    task automatic test_busy_drop();
        logic [37:0] j;
        j = '0; j[25:18] = 8'h20;
        do_cmd(1, 0, 0, j, 0, 32'h0, 0);
        do_cmd(0, 0, 1, '0, 2, 32'h5566_7788, 1);
        total++;
        if (bus.monitor_error !== 1'b1 || bus.MonDReg !== 32'h5566_7788 || bus.mem_addr !== 8'h21 || obs_strobes !== 3) begin
            bad++; $display("[TB] FAIL busy_drop: got err=%b mon=%h addr=%h n=%0d want 1 55667788 21 3",
                bus.monitor_error, bus.MonDReg, bus.mem_addr, obs_strobes);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            bit a, b, na, inj;
            logic [37:0] j;
            int stall;
            logic [31:0] rd;
            a  = ($urandom_range(0, 2) == 0);
            b  = ($urandom_range(0, 2) == 0);
            na = ($urandom_range(0, 2) == 0);
            j  = 38'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) j[25:18] = 8'hFF;
            stall = $urandom_range(0, 6);
            rd  = $urandom();
            inj = ($urandom_range(0, 4) == 0) && (b || na || (a && j[35]));
            do_cmd(a, b, na, j, stall, rd, inj);
            total++;
            if (obs_hang || obs_overlap || obs_ready_bad) begin
                bad++; $display("[TB] FAIL rand_proto[%0d]: got hang=%b overlap=%b ready_busy=%b want 0 0 0",
                    i, obs_hang, obs_overlap, obs_ready_bad);
            end
            total++;
            if (obs_strobes !== exp_strobes || obs_busy !== exp_busy ||
                obs_wr !== (exp_kind == 1) || obs_rd !== (exp_kind == 2)) begin
                bad++; $display("[TB] FAIL rand_timing[%0d]: got n=%0d busy=%0d wr=%b rd=%b want %0d %0d kind=%0d",
                    i, obs_strobes, obs_busy, obs_wr, obs_rd, exp_strobes, exp_busy, exp_kind);
            end
            total++;
            if (bus.mem_addr !== m_addr || bus.mem_wdata !== m_wdata || bus.MonDReg !== m_mon) begin
                bad++; $display("[TB] FAIL rand_regs[%0d]: got %h %h %h want %h %h %h",
                    i, bus.mem_addr, bus.mem_wdata, bus.MonDReg, m_addr, m_wdata, m_mon);
            end
            total++;
            if (bus.monitor_ready !== m_ready || bus.monitor_error !== m_err) begin
                bad++; $display("[TB] FAIL rand_status[%0d]: got ready=%b err=%b want %b %b",
                    i, bus.monitor_ready, bus.monitor_error, m_ready, m_err);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bus.take_no_action_ocimem_a = 1'b1;
        bus.mem_wait = 1'b1;
        @(posedge clk); #1;
        bus.take_no_action_ocimem_a = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.mem_rd !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_read_setup: got rd=%b want 1", bus.mem_rd);
        end
        reset_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({bus.mem_rd, bus.mem_wr, bus.busy, bus.mem_addr, bus.mem_wdata, bus.MonDReg,
             bus.monitor_ready, bus.monitor_error} !== {3'b000, 8'h0, 32'h0, 32'h0, 2'b10}) begin
            bad++; $display("[TB] FAIL async_reset: got rd=%b wr=%b busy=%b addr=%h wd=%h mon=%h rdy=%b err=%b want all zero rdy=1",
                bus.mem_rd, bus.mem_wr, bus.busy, bus.mem_addr, bus.mem_wdata, bus.MonDReg,
                bus.monitor_ready, bus.monitor_error);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("[TB] FAIL post_release: got rd=%b wr=%b busy=%b want 0 0 0", bus.mem_rd, bus.mem_wr, bus.busy);
        end
        bus.mem_wait = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_addr();
        test_write();
        test_read_wrap();
        test_priority();
        test_timeout();
        test_busy_drop();
        test_random();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
